// File: rtl/gol_row_engine.sv
// Game-of-Life row engine: streams one generation from a row-wide memory into a write buffer.
// Define GOL_POPCOUNT_EN to add a live-cell population output for the generation written.
module gol_row_engine #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned HEIGHT       = 24,
    parameter bit          WRAP         = 1'b1,
    parameter logic [8:0]  BIRTH_MASK   = 9'b000001000,
    parameter logic [8:0]  SURVIVE_MASK = 9'b000001100,
    localparam int unsigned ROW_W       = $clog2(HEIGHT)
`ifdef GOL_POPCOUNT_EN
    , localparam int unsigned POP_W     = $clog2(WIDTH * HEIGHT + 1)
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [ROW_W-1:0] rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic [15:0]      gen_count
`ifdef GOL_POPCOUNT_EN
    ,
    output logic [POP_W-1:0] population
`endif
);

    localparam int unsigned CNT_W = $clog2(HEIGHT + 7);
    localparam logic [CNT_W-1:0] LastRd     = CNT_W'(HEIGHT + 2);
    localparam logic [CNT_W-1:0] LastWr     = CNT_W'(HEIGHT + 5);
    localparam logic [CNT_W-1:0] FirstShift = CNT_W'(2);
    localparam logic [CNT_W-1:0] LastShift  = CNT_W'(HEIGHT + 3);
    localparam logic [CNT_W-1:0] FirstCalc  = CNT_W'(5);
    localparam logic [CNT_W-1:0] LastCalc   = CNT_W'(HEIGHT + 4);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cyc_q;  // cycle index relative to the accepting cycle (cycle 0)
    logic [ROW_W-1:0] rd_row;
    logic             accept, shift, edge_row, calc;
    logic [WIDTH-1:0] up_q, mid_q, dn_q;
    logic [WIDTH-1:0] nb [8];
    logic [WIDTH-1:0] next_row;
    logic [3:0]       cnt;
    logic             wr_en_q;
    logic [ROW_W-1:0] wr_addr_q;
    logic [WIDTH-1:0] wr_data_q;
    logic [15:0]      gen_q;

    assign accept = start && (state_q == StIdle || state_q == StDone);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StFetch;
            StFetch: if (cyc_q == LastRd) state_d = StDrain;
            StDrain: if (cyc_q == LastWr) state_d = StDone;
            StDone:  state_d = start ? StFetch : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        unique case (state_q)
            StFetch: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = rd_row;
            end
            StDrain: busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // Read k (issued in cycle k+1) walks H-1, 0 .. H-1, 0 so the window wraps vertically.
    always_comb begin
        if (cyc_q == CNT_W'(1))   rd_row = ROW_W'(HEIGHT - 1);
        else if (cyc_q == LastRd) rd_row = '0;
        else                      rd_row = ROW_W'(cyc_q - CNT_W'(2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cyc_q <= '0;
        else if (accept) cyc_q <= CNT_W'(1);
        else if (busy)   cyc_q <= cyc_q + CNT_W'(1);
    end

    assign shift    = busy && cyc_q >= FirstShift && cyc_q <= LastShift;
    assign edge_row = (cyc_q == FirstShift) || (cyc_q == LastShift);
    assign calc     = busy && cyc_q >= FirstCalc && cyc_q <= LastCalc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q  <= '0;
            mid_q <= '0;
            dn_q  <= '0;
        end else if (shift) begin
            up_q  <= mid_q;
            mid_q <= dn_q;
            dn_q  <= (!WRAP && edge_row) ? '0 : rd_data;
        end
    end

    // west[i] = row[i-1], east[i] = row[i+1]; the edge bit wraps or reads dead.
    function automatic logic [WIDTH-1:0] west(input logic [WIDTH-1:0] row);
        return {row[WIDTH-2:0], WRAP ? row[WIDTH-1] : 1'b0};
    endfunction

    function automatic logic [WIDTH-1:0] east(input logic [WIDTH-1:0] row);
        return {WRAP ? row[0] : 1'b0, row[WIDTH-1:1]};
    endfunction

    assign nb[0] = up_q;
    assign nb[1] = west(up_q);
    assign nb[2] = east(up_q);
    assign nb[3] = west(mid_q);
    assign nb[4] = east(mid_q);
    assign nb[5] = dn_q;
    assign nb[6] = west(dn_q);
    assign nb[7] = east(dn_q);

    always_comb begin
        next_row = '0;
        cnt      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = '0;
            for (int j = 0; j < 8; j++) cnt = cnt + 4'(nb[j][i]);
            next_row[i] = mid_q[i] ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= calc;
            if (calc) begin
                wr_addr_q <= ROW_W'(cyc_q - FirstCalc);
                wr_data_q <= next_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                gen_q <= '0;
        else if (state_q == StDone) gen_q <= gen_q + 16'd1;
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign gen_count = gen_q;

`ifdef GOL_POPCOUNT_EN
    logic [POP_W-1:0] pop_q, row_pop;

    always_comb begin
        row_pop = '0;
        for (int i = 0; i < WIDTH; i++) row_pop = row_pop + POP_W'(wr_data_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pop_q <= '0;
        else if (accept)  pop_q <= '0;
        else if (wr_en_q) pop_q <= pop_q + row_pop;
    end

    assign population = pop_q;
`endif

endmodule

// File: tb/tb_gol_row_engine.sv
// Bench for gol_row_engine: three instances (torus/B3S23, dead border, HighLife) on 32x24 grids,
// each with a row memory model; written rows are checked against a cell-wise reference model.
module tb_gol_row_engine;

    localparam int W     = 32;
    localparam int H     = 24;
    localparam int ND    = 3;
    localparam int POP_W = $clog2(W * H + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic         start     [ND];
    logic         busy      [ND];
    logic         done      [ND];
    logic         rd_en     [ND];
    logic         wr_en     [ND];
    logic [4:0]   rd_addr   [ND];
    logic [4:0]   wr_addr   [ND];
    logic [W-1:0] rd_data   [ND];
    logic [W-1:0] wr_data   [ND];
    logic [15:0]  gen_count [ND];
`ifdef GOL_POPCOUNT_EN
    logic [POP_W-1:0] population [ND];
`endif

    logic [W-1:0] mem  [ND][H];
    logic [W-1:0] wbuf [ND][H];
    logic [W-1:0] exp_g [H];

    typedef struct packed {
        logic [4:0]   addr;
        logic [W-1:0] data;
    } wr_t;
    wr_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int gc_exp [ND];

    always #5 clk = ~clk;

    gol_row_engine #(.WIDTH(W), .HEIGHT(H)) u_torus (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .wr_en(wr_en[0]),
        .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .gen_count(gen_count[0])
`ifdef GOL_POPCOUNT_EN
        , .population(population[0])
`endif
    );

    gol_row_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(1'b0)) u_border (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .wr_en(wr_en[1]),
        .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .gen_count(gen_count[1])
`ifdef GOL_POPCOUNT_EN
        , .population(population[1])
`endif
    );

    gol_row_engine #(.WIDTH(W), .HEIGHT(H), .BIRTH_MASK(9'b001001000)) u_highlife (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .rd_data(rd_data[2]), .wr_en(wr_en[2]),
        .wr_addr(wr_addr[2]), .wr_data(wr_data[2]), .gen_count(gen_count[2])
`ifdef GOL_POPCOUNT_EN
        , .population(population[2])
`endif
    );

    // Row memory: read data one cycle after rd_en; writes land in a separate buffer.
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            rd_data[d] <= rd_en[d] ? mem[d][rd_addr[d]] : '0;
            if (wr_en[d]) wbuf[d][wr_addr[d]] <= wr_data[d];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Plain cell-by-cell reference generation for instance d into exp_g.
    function automatic void ref_gen(input int d);
        logic [8:0] bm;
        logic [8:0] sm;
        bit         wrap;
        int         n, rr, cc;
        bm   = (d == 2) ? 9'b001001000 : 9'b000001000;
        sm   = 9'b000001100;
        wrap = (d != 1);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
                            if (wrap) begin
                                rr = (rr + H) % H;
                                cc = (cc + W) % W;
                            end
                            if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                                n += int'(mem[d][rr][cc]);
                        end
                    end
                end
                exp_g[r][c] = mem[d][r][c] ? sm[n] : bm[n];
            end
        end
    endfunction

    task automatic clear(input int d);
        for (int r = 0; r < H; r++) mem[d][r] = '0;
    endtask

    // One generation on instance d. repulse pokes start in cycles 3 and 10; rst_cyc > 0 pulls
    // reset in that cycle and abandons the run.
    task automatic run_gen(input int d, input bit repulse, input int rst_cyc);
        int  rd0, wr0, lat, pop, quiet;
        wr_t e;
        ref_gen(d);
        pop = 0;
        for (int r = 0; r < H; r++) begin
            sb_q.push_back({5'(r), exp_g[r]});
            pop += $countones(exp_g[r]);
        end
        rd0 = 0;
        wr0 = 0;
        lat = 0;
        @(negedge clk);
        start[d] = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            start[d] = repulse && (c == 3 || c == 10);
            if (c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                chk("rst_ctrl", 64'({busy[d], done[d], rd_en[d], wr_en[d]}), 64'(0));
                chk("rst_addr", 64'({rd_addr[d], wr_addr[d]}), 64'(0));
                chk("rst_wr_data", 64'(wr_data[d]), 64'(0));
                chk("rst_gen_count", 64'(gen_count[d]), 64'(0));
                chk("reads_before_rst", 64'(rd0), 64'(rst_cyc - 1));
                chk("writes_before_rst", 64'(wr0), 64'(rst_cyc - 6));
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                quiet = 0;
                repeat (40) begin
                    @(negedge clk);
                    if (wr_en[d] || rd_en[d]) quiet++;
                end
                chk("no_access_after_rst", 64'(quiet), 64'(0));
                for (int i = 0; i < ND; i++) begin
                    chk("gen_count_after_rst", 64'(gen_count[i]), 64'(0));
                    gc_exp[i] = 0;
                end
                sb_q.delete();
                return;
            end
            if (rd_en[d]) begin
                chk("rd_addr", 64'(rd_addr[d]), 64'(rd0 == 0 ? H - 1 : (rd0 - 1) % H));
                rd0++;
            end
            if (wr_en[d]) begin
                if (sb_q.size() == 0) chk("wr_unexpected", 64'(1), 64'(0));
                else begin
                    e = sb_q.pop_front();
                    chk("wr_row", 64'({wr_addr[d], wr_data[d]}), 64'(e));
                end
                wr0++;
            end
            if (done[d]) begin
                lat = c;
                chk("busy_in_done", 64'(busy[d]), 64'(0));
`ifdef GOL_POPCOUNT_EN
                chk("population", 64'(population[d]), 64'(pop));
`endif
            end else begin
                if (c <= H + 5) chk("busy", 64'(busy[d]), 64'(1));
                @(negedge clk);
            end
        end
        start[d] = 1'b0;
        chk("done_latency", 64'(lat), 64'(H + 6));
        chk("rd_count", 64'(rd0), 64'(H + 2));
        chk("wr_count", 64'(wr0), 64'(H));
        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        sb_q.delete();
        @(negedge clk);
        gc_exp[d]++;
        chk("done_pulse", 64'(done[d]), 64'(0));
        chk("gen_count", 64'(gen_count[d]), 64'(gc_exp[d]));
`ifdef GOL_POPCOUNT_EN
        chk("population_hold", 64'(population[d]), 64'(pop));
`endif
        for (int r = 0; r < H; r++) mem[d][r] = wbuf[d][r];
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            start[d]  = 1'b0;
            gc_exp[d] = 0;
            clear(d);
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("reset_ctrl", 64'({busy[d], done[d], rd_en[d], wr_en[d]}), 64'(0));
            chk("reset_data", 64'({rd_addr[d], wr_addr[d], wr_data[d]}), 64'(0));
            chk("reset_gen_count", 64'(gen_count[d]), 64'(0));
        end
        rst_n = 1'b1;

        // Horizontal blinker at row 5, columns 10..12 turns vertical on column 11.
        clear(0);
        mem[0][5] = 32'h0000_1C00;
        run_gen(0, 1'b0, 0);
        for (int r = 0; r < H; r++)
            chk("blinker_row", 64'(mem[0][r]), 64'((r >= 4 && r <= 6) ? 32'h0000_0800 : 32'h0));

        // Glider straddling the torus corner moves +1 row, +1 column in 4 generations.
        clear(0);
        mem[0][23] = 32'h0000_0001;
        mem[0][0]  = 32'h0000_0002;
        mem[0][1]  = 32'h8000_0003;
        repeat (4) run_gen(0, 1'b0, 0);
        for (int r = 0; r < H; r++)
            chk("glider_row", 64'(mem[0][r]),
                64'(r == 0 ? 32'h2 : r == 1 ? 32'h4 : r == 2 ? 32'h7 : 32'h0));
        chk("glider_gen_count", 64'(gen_count[0]), 64'(5));

        // Fully alive torus: every cell has 8 neighbours and dies.
        for (int r = 0; r < H; r++) mem[0][r] = '1;
        run_gen(0, 1'b0, 0);
        chk("all_alive_dies", 64'(mem[0][7] | mem[0][0] | mem[0][23]), 64'(0));

        // R-pentomino grows to 6 cells after one generation.
        clear(0);
        mem[0][10] = 32'h0000_1800;
        mem[0][11] = 32'h0000_0C00;
        mem[0][12] = 32'h0000_0800;
        run_gen(0, 1'b0, 0);
`ifdef GOL_POPCOUNT_EN
        repeat (5) @(negedge clk);
        chk("rpent_population", 64'(population[0]), 64'(6));
`endif

        // Dead border: corner block is still life; column-0 blinker loses its west side.
        clear(1);
        mem[1][0] = 32'h3;
        mem[1][1] = 32'h3;
        run_gen(1, 1'b0, 0);
        for (int r = 0; r < H; r++)
            chk("border_block", 64'(mem[1][r]), 64'(r <= 1 ? 32'h3 : 32'h0));
        clear(1);
        mem[1][0] = 32'h1;
        mem[1][1] = 32'h1;
        mem[1][2] = 32'h1;
        run_gen(1, 1'b0, 0);
        for (int r = 0; r < H; r++)
            chk("border_blinker", 64'(mem[1][r]), 64'(r == 1 ? 32'h3 : 32'h0));

        // Cell (10,10) with exactly six live neighbours: born under B36 only.
        for (int d = 0; d < ND; d += 2) begin
            clear(d);
            mem[d][9]  = 32'h0000_0E00;
            mem[d][11] = 32'h0000_0E00;
            run_gen(d, 1'b0, 0);
        end
        chk("highlife_birth6", 64'(mem[2][10][10]), 64'(1));
        chk("b3_no_birth6", 64'(mem[0][10][10]), 64'(0));

        // Protocol: start pokes while busy are ignored; reset mid-run abandons it.
        clear(0);
        mem[0][5] = 32'h0000_1C00;
        run_gen(0, 1'b1, 0);
        run_gen(0, 1'b0, 12);
        run_gen(0, 1'b0, 0);
        chk("gen_count_after_recovery", 64'(gen_count[0]), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
